mips_mem_sequencer: RTL and testbench
=====================================

Name: mips_mem_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath. It shares one single-ported memory between instruction fetch and data access.
- Consumes the instruction-class outputs of mips_decode (mem_read, word_we, byte_we, byte_load, addm, writeenable, except).
- Drives the register-file, PC, IR and MDR write enables and the memory request handshake.
- Owns the bus timeout and the halt-on-exception behaviour.

Parameters:
- TIMEOUT, 15: consecutive mem_ready-low cycles tolerated on one request before bus error; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- mem_read  in  1  decoder: load-type instruction (lw/lbu)
- word_we  in  1  decoder: sw
- byte_we  in  1  decoder: sb
- byte_load  in  1  decoder: lbu
- addm  in  1  decoder: addm
- writeenable  in  1  decoder register-write request
- except  in  1  decoder: unrecognised instruction
- mem_ready  in  1  memory: transfer completes on this edge
- mem_req  out  1  memory request, held until accepted
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- mem_write  out  1  request is a write
- mem_byte  out  1  byte-sized access
- ir_we  out  1  capture fetched instruction
- mdr_we  out  1  capture memory read data
- pc_we  out  1  commit next PC (the mux is steered externally by control_type)
- rf_we  out  1  register-file write enable
- alu_src_mdr  out  1  ALU operand 2 = MDR (second addm pass)
- halted  out  1  sticky halt
- bus_err  out  1  sticky; halt was caused by timeout
- state  out  3  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, ADDM=4, WB=5, HALT=7. Codes 6 and any illegal code go to HALT.
- Reset:
  - reset low asynchronously forces state=FETCH, wait counter=0, halted=0, bus_err=0.
  - All other outputs are 0 while reset is low; mem_req is gated by reset.
  - Reset asserted mid-transaction aborts the transaction with no write-enable glitch.
- Outputs are Moore-decoded from state, except the completion strobes (ir_we, mdr_we, and pc_we in MEM). Those are qualified by mem_ready in the same cycle.
- Handshake:
  - mem_req, mem_addr_sel, mem_write and mem_byte stay stable while waiting.
  - mem_ready is only meaningful while mem_req=1.
  - Completion happens on the rising edge where mem_req=1 and mem_ready=1; the FSM leaves the state on that edge.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_write=0, mem_byte=0.
  - On ready: ir_we=1 that cycle, go to DECODE.
- DECODE:
  - One cycle; decoder outputs settle from IR.
  - except=1: go to HALT with halted=1, and assert no rf_we or pc_we. Otherwise go to EXEC.
- EXEC:
  - If none of mem_read, word_we, byte_we, addm is set: rf_we=writeenable, pc_we=1, go to FETCH. This covers ALU ops, lui, slt, branches and jumps.
  - Otherwise go to MEM.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_write=word_we|byte_we, mem_byte=byte_we|byte_load.
  - On ready:
    - Store: pc_we=1, go to FETCH.
    - Load: mdr_we=1, go to WB.
    - addm: mdr_we=1, go to ADDM.
- WB: rf_we=1, pc_we=1, go to FETCH.
- ADDM: alu_src_mdr=1, rf_we=1, pc_we=1, go to FETCH.
- Latency with zero-wait memory:
  - ALU/branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - addm: 5 cycles.
  - Each memory wait cycle adds 1.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments on each cycle with mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT (with TIMEOUT≠0), go to HALT with halted=1 and bus_err=1 on the next edge.
  - mem_ready arriving in that same cycle wins: the transfer completes and there is no error.
- HALT:
  - All strobes and mem_req are 0; halted=1; bus_err holds its value.
  - Only reset leaves HALT.
- rf_we and pc_we are never asserted in the same cycle as mem_req=1 with mem_ready=0.

Decomposition:
- The state encodings (FETCH..HALT) go in the shared define header next to the OP_*/OP0_* opcode defines.
- One natural sub-module: mem_wait_timer. It holds the CNT_W counter, clear/increment inputs and the timeout flag.

Test Plan:
- Reset low mid-FETCH with mem_ready=0 → state=0, mem_req=0 and all strobes 0 while low. Release reset → mem_req=1 on the first cycle.
- add with zero-wait memory → ir_we at cycle 1, rf_we=1 and pc_we=1 at cycle 3, back in FETCH at cycle 4.
- lw with 2 wait cycles in MEM → mem_addr_sel=1 held 3 cycles, mdr_we=1 only in the ready cycle, then WB with rf_we=1.
- addm → sequence FETCH, DECODE, EXEC, MEM, ADDM; alu_src_mdr=1 and rf_we=1 only in ADDM. sb → mem_write=1, mem_byte=1, rf_we never asserted.
- except=1 in DECODE → HALT, halted=1, bus_err=0, no pc_we. Stays halted for 20 cycles until reset.
- TIMEOUT=15 with mem_ready stuck low in FETCH → halted=1 and bus_err=1 after 15 wait cycles. Repeat with mem_ready=1 on wait cycle 15 → normal completion, no error.

Source files
------------

// File: rtl/mips_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_sequencer_pkg
// Shared types for the multi-cycle MIPS memory sequencer.
// Contents:
//   state_t   - FSM state encoding. The value is also exported on the debug
//               state port. Code 6 is unused.
//   needs_mem - true when the decoded instruction needs a data-memory pass.
// ---------------------------------------------------------------------------
package mips_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_ADDM   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd7
  } state_t;

  // Loads, stores and addm all need the MEM state. Every other instruction
  // retires straight out of EXEC.
  function automatic logic needs_mem(input logic mem_read, input logic word_we,
                                     input logic byte_we, input logic addm);
    return mem_read | word_we | byte_we | addm;
  endfunction

endpackage

// File: rtl/mips_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// mips_mem_sequencer_if
// Request/ready handshake to the single-ported memory.
//   mem_req      - request, held until mem_ready is seen
//   mem_addr_sel - 0 = PC, 1 = ALU result
//   mem_write    - request is a write
//   mem_byte     - byte-sized access
//   mem_ready    - the transfer completes on this rising edge
// Modports:
//   master - the sequencer side
//   slave  - the memory side
// ---------------------------------------------------------------------------
interface mips_mem_sequencer_if;
  logic mem_req;
  logic mem_addr_sel;
  logic mem_write;
  logic mem_byte;
  logic mem_ready;

  modport master (output mem_req, output mem_addr_sel, output mem_write,
                  output mem_byte, input mem_ready);
  modport slave  (input mem_req, input mem_addr_sel, input mem_write,
                  input mem_byte, output mem_ready);
endinterface

// File: rtl/mips_mem_sequencer_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts the mem_ready-low cycles of the outstanding memory request.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset
//   clr     - clear the count; takes priority over inc
//   inc     - count one wait cycle
//   timeout - the count has reached TIMEOUT. This output is never asserted
//             when TIMEOUT = 0.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;

  // The count saturates so that a disabled timeout cannot wrap the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  assign timeout = (TIMEOUT != 0) && (cnt_reg >= LIMIT);

endmodule

// File: rtl/mips_mem_sequencer.sv
// ---------------------------------------------------------------------------
// mips_mem_sequencer
// Multi-cycle control FSM for the MIPS datapath. Instruction fetch and data
// access share one memory port.
// Ports:
//   clock, reset (async, active-low)
//   mem_read, word_we, byte_we, byte_load, addm, writeenable, except
//       - instruction class from the decoder
//   bus         - memory handshake (master modport)
//   ir_we       - write enable for the IR
//   mdr_we      - write enable for the MDR
//   pc_we       - write enable for the PC
//   rf_we       - write enable for the register file
//   alu_src_mdr - ALU operand 2 = MDR (second pass of addm)
//   halted      - sticky halt
//   bus_err     - sticky; the halt came from a bus timeout
//   state       - current state, for debug
// ---------------------------------------------------------------------------
module mips_mem_sequencer
  import mips_mem_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mem_read,
  input  logic                        word_we,
  input  logic                        byte_we,
  input  logic                        byte_load,
  input  logic                        addm,
  input  logic                        writeenable,
  input  logic                        except,
  mips_mem_sequencer_if.master        bus,
  output logic                        ir_we,
  output logic                        mdr_we,
  output logic                        pc_we,
  output logic                        rf_we,
  output logic                        alu_src_mdr,
  output logic                        halted,
  output logic                        bus_err,
  output logic [2:0]                  state
);

  state_t state_reg;
  logic   halted_reg;
  logic   bus_err_reg;
  logic   timeout;
  logic   mem_op;
  logic   is_store;
  logic   in_fetch;
  logic   in_mem;

  assign mem_op   = needs_mem(mem_read, word_we, byte_we, addm);
  assign is_store = word_we | byte_we;
  assign in_fetch = (state_reg == ST_FETCH);
  assign in_mem   = (state_reg == ST_MEM);

  // While no request is outstanding, and on every completion, the counter is
  // cleared. So each FETCH or MEM request starts counting from zero.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (~bus.mem_req | bus.mem_ready),
    .inc     (bus.mem_req & ~bus.mem_ready),
    .timeout (timeout)
  );

  // In FETCH and MEM, mem_ready is tested before the timeout, so a transfer
  // that completes on the last allowed cycle is not reported as an error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_FETCH;
      halted_reg  <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            state_reg <= ST_DECODE;
          end else if (timeout) begin
            state_reg   <= ST_HALT;
            halted_reg  <= 1'b1;
            bus_err_reg <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (except) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: state_reg <= mem_op ? ST_MEM : ST_FETCH;
        ST_MEM: begin
          if (bus.mem_ready) begin
            if (is_store)  state_reg <= ST_FETCH;
            else if (addm) state_reg <= ST_ADDM;
            else           state_reg <= ST_WB;
          end else if (timeout) begin
            state_reg   <= ST_HALT;
            halted_reg  <= 1'b1;
            bus_err_reg <= 1'b1;
          end
        end
        ST_WB, ST_ADDM: state_reg <= ST_FETCH;
        ST_HALT: halted_reg <= 1'b1;
        default: begin
          state_reg  <= ST_HALT;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

  // The outputs are decoded from the state register. Each one is gated by
  // reset, so an asynchronous reset drops the request and every strobe at
  // once, even while the state register still reads FETCH.
  assign bus.mem_req      = reset & (in_fetch | in_mem);
  assign bus.mem_addr_sel = reset & in_mem;
  assign bus.mem_write    = reset & in_mem & is_store;
  assign bus.mem_byte     = reset & in_mem & (byte_we | byte_load);

  assign ir_we       = reset & in_fetch & bus.mem_ready;
  assign mdr_we      = reset & in_mem & bus.mem_ready & ~is_store;
  assign pc_we       = reset & (((state_reg == ST_EXEC) & ~mem_op) |
                                (in_mem & bus.mem_ready & is_store) |
                                (state_reg == ST_WB) | (state_reg == ST_ADDM));
  assign rf_we       = reset & (((state_reg == ST_EXEC) & ~mem_op & writeenable) |
                                (state_reg == ST_WB) | (state_reg == ST_ADDM));
  assign alu_src_mdr = reset & (state_reg == ST_ADDM);

  assign halted  = halted_reg;
  assign bus_err = bus_err_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_mips_mem_sequencer.sv
module tb_mips_mem_sequencer;
  import mips_mem_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_read = 1'b0, word_we = 1'b0, byte_we = 1'b0, byte_load = 1'b0;
  logic addm = 1'b0, writeenable = 1'b0, except = 1'b0;
  logic mem_ready = 1'b0;
  logic ir_we, mdr_we, pc_we, rf_we, alu_src_mdr, halted, bus_err;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  mips_mem_sequencer_if bus_if ();
  assign bus_if.mem_ready = mem_ready;

  mips_mem_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_read    (mem_read),
    .word_we     (word_we),
    .byte_we     (byte_we),
    .byte_load   (byte_load),
    .addm        (addm),
    .writeenable (writeenable),
    .except      (except),
    .bus         (bus_if),
    .ir_we       (ir_we),
    .mdr_we      (mdr_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .alu_src_mdr (alu_src_mdr),
    .halted      (halted),
    .bus_err     (bus_err),
    .state       (state)
  );

  always #5 clock = ~clock;

  // Decoder patterns, bit order {mem_read, word_we, byte_we, byte_load, addm, writeenable, except}
  localparam logic [6:0] D_ADD  = 7'b0000010;
  localparam logic [6:0] D_LW   = 7'b1000010;
  localparam logic [6:0] D_ADDM = 7'b0000110;
  localparam logic [6:0] D_SB   = 7'b0010000;
  localparam logic [6:0] D_LBU  = 7'b1001010;
  localparam logic [6:0] D_SW   = 7'b0100000;
  localparam logic [6:0] D_BR   = 7'b0000000;
  localparam logic [6:0] D_EXC  = 7'b0000001;

  // Output patterns, bit order {req, addr_sel, write, byte, ir_we, mdr_we, pc_we, rf_we, alu_src_mdr, halted, bus_err}
  localparam logic [10:0] O_IDLE       = 11'b00000000000;
  localparam logic [10:0] O_FETCH_RDY  = 11'b10001000000;
  localparam logic [10:0] O_FETCH_WAIT = 11'b10000000000;
  localparam logic [10:0] O_EXEC_WE    = 11'b00000011000;
  localparam logic [10:0] O_EXEC_BR    = 11'b00000010000;
  localparam logic [10:0] O_LD_WAIT    = 11'b11000000000;
  localparam logic [10:0] O_LD_RDY     = 11'b11000100000;
  localparam logic [10:0] O_WB         = 11'b00000011000;
  localparam logic [10:0] O_ADDM       = 11'b00000011100;
  localparam logic [10:0] O_SB_RDY     = 11'b11110010000;
  localparam logic [10:0] O_LBU_RDY    = 11'b11010100000;
  localparam logic [10:0] O_SW_WAIT    = 11'b11100000000;
  localparam logic [10:0] O_SW_RDY     = 11'b11100010000;
  localparam logic [10:0] O_HALT       = 11'b00000000010;
  localparam logic [10:0] O_BUSERR     = 11'b00000000011;

  typedef struct {
    logic [6:0]  dec;
    logic        rdy;
    logic [2:0]  st;
    logic [10:0] o;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] outs();
    return {bus_if.mem_req, bus_if.mem_addr_sel, bus_if.mem_write, bus_if.mem_byte,
            ir_we, mdr_we, pc_we, rf_we, alu_src_mdr, halted, bus_err};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] st, input logic [10:0] o);
    check({name, ".state"}, 11'(state), 11'(st));
    check({name, ".outs"}, outs(), o);
    $display("[TB] %s state=%0d outs=%b", name, state, outs());
  endtask

  task automatic set_dec(input logic [6:0] d);
    {mem_read, word_we, byte_we, byte_load, addm, writeenable, except} = d;
  endtask

  task automatic add(input logic [6:0] d, input logic r, input logic [2:0] s, input logic [10:0] o);
    vec_t v;
    v.dec = d; v.rdy = r; v.st = s; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // add, zero wait
    add(D_ADD, 1, 3'd0, O_FETCH_RDY); add(D_ADD, 0, 3'd1, O_IDLE); add(D_ADD, 0, 3'd2, O_EXEC_WE);
    // lw, two wait cycles in MEM
    add(D_LW, 1, 3'd0, O_FETCH_RDY); add(D_LW, 0, 3'd1, O_IDLE); add(D_LW, 0, 3'd2, O_IDLE);
    add(D_LW, 0, 3'd3, O_LD_WAIT); add(D_LW, 0, 3'd3, O_LD_WAIT); add(D_LW, 1, 3'd3, O_LD_RDY);
    add(D_LW, 0, 3'd5, O_WB);
    // addm
    add(D_ADDM, 1, 3'd0, O_FETCH_RDY); add(D_ADDM, 0, 3'd1, O_IDLE); add(D_ADDM, 0, 3'd2, O_IDLE);
    add(D_ADDM, 1, 3'd3, O_LD_RDY); add(D_ADDM, 0, 3'd4, O_ADDM);
    // sb
    add(D_SB, 1, 3'd0, O_FETCH_RDY); add(D_SB, 0, 3'd1, O_IDLE); add(D_SB, 0, 3'd2, O_IDLE);
    add(D_SB, 1, 3'd3, O_SB_RDY);
    // lbu
    add(D_LBU, 1, 3'd0, O_FETCH_RDY); add(D_LBU, 0, 3'd1, O_IDLE); add(D_LBU, 0, 3'd2, O_IDLE);
    add(D_LBU, 1, 3'd3, O_LBU_RDY); add(D_LBU, 0, 3'd5, O_WB);
    // sw, one wait cycle
    add(D_SW, 1, 3'd0, O_FETCH_RDY); add(D_SW, 0, 3'd1, O_IDLE); add(D_SW, 0, 3'd2, O_IDLE);
    add(D_SW, 0, 3'd3, O_SW_WAIT); add(D_SW, 1, 3'd3, O_SW_RDY);
    // branch (no register write) with one wait cycle in FETCH
    add(D_BR, 0, 3'd0, O_FETCH_WAIT); add(D_BR, 1, 3'd0, O_FETCH_RDY); add(D_BR, 0, 3'd1, O_IDLE);
    add(D_BR, 0, 3'd2, O_EXEC_BR);

    // Reset state, with mem_ready high to show that ir_we is gated by reset.
    mem_ready = 1'b1;
    @(negedge clock);
    check_all("reset", 3'd0, O_IDLE);
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_dec(vecs[i].dec);
      mem_ready = vecs[i].rdy;
      @(negedge clock);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].o);
      next_cycle();
    end

    // Reset asserted mid-MEM with a store pending: the store is aborted and no pc_we pulse appears.
    set_dec(D_SW);
    mem_ready = 1'b1; next_cycle();
    mem_ready = 1'b0; next_cycle();
    next_cycle();
    @(negedge clock);
    check_all("sw_mem_wait", 3'd3, O_SW_WAIT);
    #1 reset = 1'b0; mem_ready = 1'b1;
    #1 check_all("rst_mid_mem", 3'd0, O_IDLE);
    next_cycle();
    check_all("rst_held", 3'd0, O_IDLE);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_all("rst_release", 3'd0, O_FETCH_WAIT);

    // except in DECODE: go to HALT without a bus error, and stay there.
    set_dec(D_EXC);
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clock);
    check_all("exc_decode", 3'd1, O_IDLE);
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      @(negedge clock);
      check_all($sformatf("exc_halt%0d", k), 3'd7, O_HALT);
      next_cycle();
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    check_all("exc_reset", 3'd0, O_IDLE);
    next_cycle();
    reset = 1'b1;

    // Timeout: 15 wait cycles are tolerated; a 16th low cycle causes a bus error.
    set_dec(D_ADD);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check_all($sformatf("to_wait%0d", k), 3'd0, O_FETCH_WAIT);
      next_cycle();
    end
    @(negedge clock);
    check_all("to_halt", 3'd7, O_BUSERR);
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clock);
    check_all("to_halt_hold", 3'd7, O_BUSERR);
    reset = 1'b0;
    mem_ready = 1'b0;
    next_cycle();
    check_all("to_reset", 3'd0, O_IDLE);
    reset = 1'b1;

    // ready arrives in the same cycle as the timeout flag: ready wins.
    for (int k = 1; k <= 15; k++) next_cycle();
    mem_ready = 1'b1;
    @(negedge clock);
    check_all("to_ready_wins", 3'd0, O_FETCH_RDY);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clock);
    check_all("to_no_err", 3'd1, O_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
